// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the branch-predicting MIPS pipeline: mispredict redirect/flush and load-use stall.
// Optional saturating performance counters are built when PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int PC_WIDTH       = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int FLUSH_CYCLES   = 2,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ex_branch_valid,
   input  logic                      ex_prediction,
   input  logic                      ex_taken,
   input  logic [PC_WIDTH-1:0]       ex_target,
   input  logic [PC_WIDTH-1:0]       ex_save_pc,
   input  logic                      ex_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
   input  logic                      perf_clr,
   output logic                      redirect_valid,
   output logic [PC_WIDTH-1:0]       redirect_pc,
   output logic                      stall_pc,
   output logic                      stall_if_id,
   output logic                      flush_if_id,
   output logic                      flush_id_ex,
   output logic [CNT_WIDTH-1:0]      mispredict_cnt,
   output logic [CNT_WIDTH-1:0]      branch_cnt,
   output logic [CNT_WIDTH-1:0]      stall_cnt
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t     state_r;
   logic [3:0] flush_left_r;
   logic       mispredict_s;
   logic       load_use_s;

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
      initial $error("pipe_hazard_ctrl: FLUSH_CYCLES=%0d outside 1..15", FLUSH_CYCLES);
   end

   assign mispredict_s = ex_branch_valid & (ex_prediction != ex_taken);
   assign load_use_s   = ex_mem_read & (ex_rd_addr != {REG_ADDR_WIDTH{1'b0}}) &
                         ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));

   // Flush sequencer: extra flush cycles after the mispredict cycle itself
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         flush_left_r <= 4'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (mispredict_s && (FLUSH_CYCLES > 1)) begin
                  state_r      <= FLUSH;
                  flush_left_r <= 4'(FLUSH_CYCLES - 1);
               end else begin
                  state_r      <= IDLE;
                  flush_left_r <= 4'd0;
               end
            end
            FLUSH: begin
               if (flush_left_r <= 4'd1) begin
                  state_r      <= IDLE;
                  flush_left_r <= 4'd0;
               end else begin
                  state_r      <= FLUSH;
                  flush_left_r <= flush_left_r - 4'd1;
               end
            end
            default: begin
               state_r      <= IDLE;
               flush_left_r <= 4'd0;
            end
         endcase
      end
   end

   // Pipeline control decode; mispredict outranks the load-use stall
   always_comb begin
      redirect_valid = 1'b0;
      redirect_pc    = {PC_WIDTH{1'b0}};
      stall_pc       = 1'b0;
      stall_if_id    = 1'b0;
      flush_if_id    = 1'b0;
      flush_id_ex    = 1'b0;
      if (reset) begin
         redirect_valid = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (mispredict_s) begin
                  redirect_valid = 1'b1;
                  redirect_pc    = ex_taken ? ex_target : ex_save_pc;
                  flush_if_id    = 1'b1;
                  flush_id_ex    = 1'b1;
               end else if (load_use_s) begin
                  stall_pc       = 1'b1;
                  stall_if_id    = 1'b1;
                  flush_id_ex    = 1'b1;
               end else begin
                  redirect_valid = 1'b0;
               end
            end
            FLUSH: begin
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end
            default: begin
               redirect_valid = 1'b0;
            end
         endcase
      end
   end

`ifdef PERF_CNT_EN
   logic [CNT_WIDTH-1:0] mispredict_cnt_r;
   logic [CNT_WIDTH-1:0] branch_cnt_r;
   logic [CNT_WIDTH-1:0] stall_cnt_r;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   endfunction

   // Saturating event counters, only sampled while not flushing
   always_ff @(posedge clk) begin
      if (reset || perf_clr) begin
         mispredict_cnt_r <= {CNT_WIDTH{1'b0}};
         branch_cnt_r     <= {CNT_WIDTH{1'b0}};
         stall_cnt_r      <= {CNT_WIDTH{1'b0}};
      end else if (state_r == IDLE) begin
         if (ex_branch_valid) begin
            branch_cnt_r <= sat_inc(branch_cnt_r);
         end
         if (mispredict_s) begin
            mispredict_cnt_r <= sat_inc(mispredict_cnt_r);
         end
         if (load_use_s && !mispredict_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
         end
      end
   end

   assign mispredict_cnt = reset ? {CNT_WIDTH{1'b0}} : mispredict_cnt_r;
   assign branch_cnt     = reset ? {CNT_WIDTH{1'b0}} : branch_cnt_r;
   assign stall_cnt      = reset ? {CNT_WIDTH{1'b0}} : stall_cnt_r;
`else
   logic unused_perf_clr_s;

   assign unused_perf_clr_s = perf_clr;
   assign mispredict_cnt    = {CNT_WIDTH{1'b0}};
   assign branch_cnt        = {CNT_WIDTH{1'b0}};
   assign stall_cnt         = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, CNT_WIDTH=4).
// Counter expectations follow PERF_CNT_EN; without it every counter must read 0.
module tb_pipe_hazard_ctrl;
   localparam int PCW = 32;
   localparam int RAW = 5;
   localparam int CW  = 4;
`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           ex_branch_valid, ex_prediction, ex_taken;
   logic [PCW-1:0] ex_target, ex_save_pc;
   logic           ex_mem_read;
   logic [RAW-1:0] ex_rd_addr, id_rs1_addr, id_rs2_addr;
   logic           perf_clr;
   logic           redirect_valid;
   logic [PCW-1:0] redirect_pc;
   logic           stall_pc, stall_if_id, flush_if_id, flush_id_ex;
   logic [CW-1:0]  mispredict_cnt, branch_cnt, stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.PC_WIDTH(PCW), .REG_ADDR_WIDTH(RAW), .FLUSH_CYCLES(2), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .ex_branch_valid(ex_branch_valid), .ex_prediction(ex_prediction), .ex_taken(ex_taken),
      .ex_target(ex_target), .ex_save_pc(ex_save_pc),
      .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .perf_clr(perf_clr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall_pc(stall_pc), .stall_if_id(stall_if_id),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .mispredict_cnt(mispredict_cnt), .branch_cnt(branch_cnt), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic rv, input logic [31:0] rpc,
                          input logic spc, input logic sif, input logic fif, input logic fex);
      chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
      chk({tag, ".redirect_pc"}, redirect_pc, rpc);
      chk({tag, ".stall_pc"}, {31'd0, stall_pc}, {31'd0, spc});
      chk({tag, ".stall_if_id"}, {31'd0, stall_if_id}, {31'd0, sif});
      chk({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, fif});
      chk({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, fex});
   endtask

   task automatic chk_cnt(input string tag, input int b, input int m, input int s);
      chk({tag, ".branch_cnt"}, {28'd0, branch_cnt}, PERF ? 32'(b) : 32'd0);
      chk({tag, ".mispredict_cnt"}, {28'd0, mispredict_cnt}, PERF ? 32'(m) : 32'd0);
      chk({tag, ".stall_cnt"}, {28'd0, stall_cnt}, PERF ? 32'(s) : 32'd0);
   endtask

   task automatic idle_inputs();
      ex_branch_valid = 1'b0; ex_prediction = 1'b0; ex_taken = 1'b0;
      ex_target = 32'h0; ex_save_pc = 32'h0;
      ex_mem_read = 1'b0; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
      perf_clr = 1'b0;
   endtask

   // Inputs change right after the falling edge; checks land 1 ns later, far from the rising edge
   task automatic next();
      @(negedge clk);
   endtask

   initial begin
      idle_inputs();
      // 1: reset held 3 cycles against a live mispredict
      reset = 1'b1;
      ex_branch_valid = 1'b1; ex_prediction = 1'b1; ex_taken = 1'b0; ex_save_pc = 32'h44;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_ctl("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         chk_cnt("reset", 0, 0, 0);
         next();
      end
      reset = 1'b0; idle_inputs();
      #1 chk_ctl("post_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // 2: correctly predicted taken branch
      next();
      ex_branch_valid = 1'b1; ex_prediction = 1'b1; ex_taken = 1'b1;
      ex_target = 32'h80; ex_save_pc = 32'h84;
      #1 chk_ctl("pred_ok", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      next(); idle_inputs();
      #1 chk_cnt("pred_ok", 1, 0, 0);

      // 3: predicted taken, not taken -> redirect to fall-through, 2 flush cycles
      next();
      ex_branch_valid = 1'b1; ex_prediction = 1'b1; ex_taken = 1'b0;
      ex_target = 32'h90; ex_save_pc = 32'h44;
      #1 chk_ctl("misp_c0", 1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1);
      // squashed branch and load-use in FLUSH are ignored
      next();
      ex_branch_valid = 1'b1; ex_prediction = 1'b0; ex_taken = 1'b1; ex_target = 32'h200;
      ex_mem_read = 1'b1; ex_rd_addr = 5'd3; id_rs1_addr = 5'd3;
      #1 chk_ctl("misp_c1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      next(); idle_inputs();
      #1 chk_ctl("misp_c2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("misp", 2, 1, 0);

      // 3b: reset in the second flush cycle aborts the flush
      next();
      ex_branch_valid = 1'b1; ex_prediction = 1'b1; ex_taken = 1'b0; ex_save_pc = 32'h44;
      #1 chk_ctl("abort_c0", 1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1);
      next(); idle_inputs(); reset = 1'b1;
      #1 chk_ctl("abort_c1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      next(); reset = 1'b0;
      #1 chk_ctl("abort_c2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("abort", 0, 0, 0);

      // 4: load-use on rs1, then on rs2, then with rd = 0
      next();
      ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs2_addr = 5'd0;
      #1 chk_ctl("lu_rs1", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      next(); idle_inputs();
      #1 chk_ctl("lu_after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      next();
      ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd3; id_rs2_addr = 5'd7;
      #1 chk_ctl("lu_rs2", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      next();
      ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
      #1 chk_ctl("lu_r0", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      next(); idle_inputs();
      #1 chk_cnt("lu", 0, 0, 2);

      // 5: mispredict and load-use together -> mispredict wins
      ex_branch_valid = 1'b1; ex_prediction = 1'b0; ex_taken = 1'b1;
      ex_target = 32'h100; ex_save_pc = 32'h48;
      ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5;
      #1 chk_ctl("both", 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1);
      next(); idle_inputs();
      #1 chk_ctl("both_c1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk_cnt("both", 1, 1, 2);
      next();
      #1 chk_ctl("both_c2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // 6: 20 more mispredicts saturate the 4-bit counters
      for (int i = 0; i < 20; i++) begin
         next();
         ex_branch_valid = 1'b1; ex_prediction = 1'b1; ex_taken = 1'b0; ex_save_pc = 32'h44;
         next(); idle_inputs();
      end
      #1 chk_cnt("sat", 15, 15, 2);
      next();
      perf_clr = 1'b1;
      ex_branch_valid = 1'b1; ex_prediction = 1'b0; ex_taken = 1'b1; ex_target = 32'h100;
      ex_mem_read = 1'b1; ex_rd_addr = 5'd9; id_rs1_addr = 5'd9;
      #1 chk_ctl("clr_misp", 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1);
      next(); idle_inputs();
      #1 chk_cnt("clr", 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
